// File: rtl/exposure_sequencer.sv
// Capture sequencer for the pixel array: Erase, Expose for the latched time,
// then a two-row readout with ADC strobes. Busy blocks upstream changes.
module exposure_sequencer #(
  parameter int unsigned CLK_PER_MS = 1,
  parameter int unsigned ERASE_MS   = 2,
  parameter int unsigned EXP_MIN    = 2,
  parameter int unsigned EXP_MAX    = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Abort,
  input  logic [4:0] Exp_Time,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic       Busy,
  output logic       Done
);

  localparam int unsigned CNT_W     = 21;
  localparam int unsigned EXP_W     = 5;
  localparam int unsigned ERASE_CYC = ERASE_MS * CLK_PER_MS;
  localparam int unsigned READ_CYC  = 2 * CLK_PER_MS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_READ1,
    S_GAP,
    S_READ2,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [EXP_W-1:0] exp_lat;
  logic [EXP_W-1:0] exp_clamp_c;
  logic [CNT_W-1:0] expose_cyc_c;

  // Clamp the incoming exposure time into the legal window
  always_comb begin
    exp_clamp_c = Exp_Time;
    if (Exp_Time < EXP_W'(EXP_MIN)) begin
      exp_clamp_c = EXP_W'(EXP_MIN);
    end else if (Exp_Time > EXP_W'(EXP_MAX)) begin
      exp_clamp_c = EXP_W'(EXP_MAX);
    end
  end

  assign expose_cyc_c = CNT_W'(exp_lat) * CNT_W'(CLK_PER_MS);

  // Next state; the phase counter is reloaded with (length - 1) on each entry
  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (Init) begin
          state_n = S_ERASE;
          cnt_n   = CNT_W'(ERASE_CYC - 1);
        end
      end
      S_ERASE: begin
        if (cnt == '0) begin
          state_n = S_EXPOSE;
          cnt_n   = expose_cyc_c - CNT_W'(1);
        end
      end
      S_EXPOSE: begin
        if (cnt == '0) begin
          state_n = S_READ1;
          cnt_n   = CNT_W'(READ_CYC - 1);
        end
      end
      S_READ1: begin
        if (cnt == '0) begin
          state_n = S_GAP;
          cnt_n   = CNT_W'(CLK_PER_MS - 1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_n = S_READ2;
          cnt_n   = CNT_W'(READ_CYC - 1);
        end
      end
      S_READ2: begin
        if (cnt == '0) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    // DONE always completes so the Done pulse is never truncated
    if (Abort && (state != S_IDLE) && (state != S_DONE)) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end
  end

  // State register with outputs decoded from the state being entered
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      exp_lat <= EXP_W'(EXP_MIN);
      Erase   <= 1'b0;
      Expose  <= 1'b0;
      NRE_1   <= 1'b1;
      NRE_2   <= 1'b1;
      ADC     <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if ((state == S_IDLE) && Init) begin
        exp_lat <= exp_clamp_c;
      end
      Erase  <= (state_n == S_ERASE);
      Expose <= (state_n == S_EXPOSE);
      NRE_1  <= (state_n != S_READ1);
      NRE_2  <= (state_n != S_READ2);
      ADC    <= ((state_n == S_READ1) || (state_n == S_READ2)) && (cnt_n == '0);
      Busy   <= (state_n != S_IDLE);
      Done   <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer: table of captures measured phase by
// phase, plus hand-written async-reset and back-to-back sequences.
module tb_exposure_sequencer;

  logic       Clk;
  logic       Reset;
  logic       init1, abort1, init4, abort4;
  logic [4:0] exp1, exp4;
  logic       erase1, expose1, nre1_1, nre2_1, adc1, busy1, done1;
  logic       erase4, expose4, nre1_4, nre2_4, adc4, busy4, done4;
  logic [6:0] o1, o4;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] IDLE_V  = 7'b0011000;
  localparam logic [6:0] ERASE_V = 7'b1011010;

  exposure_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Init(init1), .Abort(abort1), .Exp_Time(exp1),
    .Erase(erase1), .Expose(expose1), .NRE_1(nre1_1), .NRE_2(nre2_1),
    .ADC(adc1), .Busy(busy1), .Done(done1)
  );

  exposure_sequencer #(.CLK_PER_MS(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Init(init4), .Abort(abort4), .Exp_Time(exp4),
    .Erase(erase4), .Expose(expose4), .NRE_1(nre1_4), .NRE_2(nre2_4),
    .ADC(adc4), .Busy(busy4), .Done(done4)
  );

  // {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done}
  assign o1 = {erase1, expose1, nre1_1, nre2_1, adc1, busy1, done1};
  assign o4 = {erase4, expose4, nre1_4, nre2_4, adc4, busy4, done4};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    bit         use4;
    logic [4:0] exp;
    int         chg_at;
    int         abort_at;
    int         init_at;
    bit         ab_init;
    int         erase;
    int         expose;
    int         nre1;
    int         nre2;
    int         adc1;
    int         adc2;
    int         gap;
    int         busy;
    int         done;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit use4, input logic i, input logic a);
    if (use4) begin
      init4 = i; abort4 = a;
    end else begin
      init1 = i; abort1 = a;
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge Clk); #1;
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int n_er = 0, n_ex = 0, n_r1 = 0, n_r2 = 0, n_a1 = 0, n_a2 = 0;
    int n_gap = 0, n_busy = 0, done_at = 0;
    bit ended = 1'b0;
    logic [6:0] s;
    string tag = $sformatf("row%0d", idx);

    @(negedge Clk);
    if (v.use4) exp4 = v.exp; else exp1 = v.exp;
    set_in(v.use4, 1'b1, v.ab_init);
    @(posedge Clk); #1;
    set_in(v.use4, 1'b0, 1'b0);
    for (int i = 1; i <= 400; i++) begin
      s = v.use4 ? o4 : o1;
      if (!s[1]) begin
        ended = 1'b1;
        break;
      end
      n_busy++;
      if (s[6]) n_er++;
      if (s[5]) n_ex++;
      if (!s[4]) n_r1++;
      if (!s[3]) n_r2++;
      if (s[2] && !s[4]) n_a1++;
      if (s[2] && !s[3]) n_a2++;
      if (s[0]) done_at = i;
      if (!s[6] && !s[5] && s[4] && s[3] && !s[2] && !s[0]) n_gap++;
      if (i == v.chg_at) begin
        if (v.use4) exp4 = 5'd9; else exp1 = 5'd9;
      end
      set_in(v.use4, (i == v.init_at), (i == v.abort_at));
      @(posedge Clk); #1;
      set_in(v.use4, 1'b0, 1'b0);
    end
    check({tag, "_ended"}, int'(ended), 1);
    check({tag, "_erase"}, n_er, v.erase);
    check({tag, "_expose"}, n_ex, v.expose);
    check({tag, "_nre1"}, n_r1, v.nre1);
    check({tag, "_nre2"}, n_r2, v.nre2);
    check({tag, "_adc_r1"}, n_a1, v.adc1);
    check({tag, "_adc_r2"}, n_a2, v.adc2);
    check({tag, "_gap"}, n_gap, v.gap);
    check({tag, "_busy"}, n_busy, v.busy);
    check({tag, "_done_cycle"}, done_at, v.done);
    s = v.use4 ? o4 : o1;
    check({tag, "_idle_after"}, int'(s), int'(IDLE_V));
    @(posedge Clk); #1;
    s = v.use4 ? o4 : o1;
    check({tag, "_idle_hold"}, int'(s), int'(IDLE_V));
  endtask

  vec_t vecs[15];

  initial begin
    // use4 exp chg abort init abinit | erase expose nre1 nre2 adc1 adc2 gap busy done
    vecs[0]  = '{1'b0, 5'd15, 0, 0, 0, 1'b0, 2, 15, 2, 2, 1, 1, 1, 23, 23};
    vecs[1]  = '{1'b0, 5'd0,  0, 0, 0, 1'b0, 2,  2, 2, 2, 1, 1, 1, 10, 10};
    vecs[2]  = '{1'b0, 5'd31, 0, 0, 0, 1'b0, 2, 30, 2, 2, 1, 1, 1, 38, 38};
    vecs[3]  = '{1'b0, 5'd1,  0, 0, 0, 1'b0, 2,  2, 2, 2, 1, 1, 1, 10, 10};
    vecs[4]  = '{1'b0, 5'd30, 0, 0, 0, 1'b0, 2, 30, 2, 2, 1, 1, 1, 38, 38};
    vecs[5]  = '{1'b0, 5'd4,  4, 0, 0, 1'b0, 2,  4, 2, 2, 1, 1, 1, 12, 12};
    vecs[6]  = '{1'b0, 5'd15, 0, 7, 0, 1'b0, 2,  5, 0, 0, 0, 0, 0,  7,  0};
    vecs[7]  = '{1'b0, 5'd6,  0, 0, 0, 1'b0, 2,  6, 2, 2, 1, 1, 1, 14, 14};
    vecs[8]  = '{1'b0, 5'd3,  0, 1, 0, 1'b0, 1,  0, 0, 0, 0, 0, 0,  1,  0};
    vecs[9]  = '{1'b0, 5'd2,  0, 7, 0, 1'b0, 2,  2, 2, 0, 1, 0, 1,  7,  0};
    vecs[10] = '{1'b0, 5'd2,  0, 10, 0, 1'b0, 2, 2, 2, 2, 1, 1, 1, 10, 10};
    vecs[11] = '{1'b0, 5'd5,  0, 0, 0, 1'b1, 2,  5, 2, 2, 1, 1, 1, 13, 13};
    vecs[12] = '{1'b0, 5'd5,  0, 0, 5, 1'b0, 2,  5, 2, 2, 1, 1, 1, 13, 13};
    vecs[13] = '{1'b1, 5'd3,  0, 0, 0, 1'b0, 8, 12, 8, 8, 1, 1, 4, 41, 41};
    vecs[14] = '{1'b1, 5'd0,  0, 0, 0, 1'b0, 8,  8, 8, 8, 1, 1, 4, 37, 37};

    init1 = 1'b0; abort1 = 1'b0; exp1 = 5'd0;
    init4 = 1'b0; abort4 = 1'b0; exp4 = 5'd0;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", int'(o1), int'(IDLE_V));
    check("reset_state4", int'(o4), int'(IDLE_V));
    @(negedge Clk) Reset = 1'b1;
    repeat (2) @(posedge Clk);

    for (int r = 0; r < 15; r++) begin
      run_row(r, vecs[r]);
    end

    // Asynchronous reset in the middle of READ1, Init held through reset
    @(negedge Clk);
    exp1 = 5'd2; init1 = 1'b1;
    @(posedge Clk); #1;
    init1 = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
    end
    check("in_read1_nre1", int'(nre1_1), 0);
    #2 Reset = 1'b0;
    init1 = 1'b1;
    #1;
    check("async_reset_idle", int'(o1), int'(IDLE_V));
    repeat (2) begin
      @(posedge Clk); #1;
    end
    check("init_in_reset_ignored", int'(o1), int'(IDLE_V));
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk); #1;
    check("start_after_reset", int'(o1), int'(ERASE_V));

    // Init held high: exactly one IDLE cycle between Done and next Erase
    wait_done("held1");
    @(posedge Clk); #1;
    check("held_idle_gap", int'(o1), int'(IDLE_V));
    @(posedge Clk); #1;
    check("held_restart", int'(o1), int'(ERASE_V));
    init1 = 1'b0;
    wait_done("held2");
    repeat (3) begin
      @(posedge Clk); #1;
    end
    check("no_retrigger", int'(o1), int'(IDLE_V));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exposure_sequencer.md
Name: exposure_sequencer

Overview:
- Consumes the 5-bit exposure time (ms, range 2-30) produced by the exposure-time control stage.
- On a start request, runs one capture cycle for the pixel array: Erase, then Expose for the latched time, then a two-row readout with ADC strobes.
- Asserts Busy so upstream logic can block exposure changes and new starts during a capture.
- Sits between the exposure-time control and the sensor/ADC interface.

Parameters:
- CLK_PER_MS, 1, Clk cycles per 1 ms tick. Legal range 1-65535.
- ERASE_MS, 2, length of the Erase phase in ms ticks. Legal range 1-15.
- EXP_MIN, 2, lower clamp for the latched exposure in ms.
- EXP_MAX, 30, upper clamp for the latched exposure in ms.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Init  in  1  start request; sampled only in IDLE.
- Abort  in  1  synchronous abort; active in any non-IDLE state.
- Exp_Time  in  5  exposure time in ms, from exposure-time control.
- Erase  out  1  pixel erase, active high.
- Expose  out  1  pixel expose, active high.
- NRE_1  out  1  row-1 read enable, active low.
- NRE_2  out  1  row-2 read enable, active low.
- ADC  out  1  ADC convert strobe, active high.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when a capture completes.

Behaviour:
- Reset low: state goes to IDLE immediately, not waiting for a clock edge.
  - All counters are cleared.
  - Output values: Erase=0, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0, Done=0.
  - Reset asserted mid-capture aborts the capture with no Done pulse.
- All outputs are registered and decoded from the state. Each phase begins on the clock edge that enters its state.
- States and transitions:
  - IDLE: if Init=1 at the edge, go to ERASE. On the same edge, latch E = clamp(Exp_Time, EXP_MIN, EXP_MAX). Exp_Time values 0-1 give 2; values 31 or higher give 30.
  - ERASE: Erase=1 for exactly ERASE_MS*CLK_PER_MS cycles, then go to EXPOSE.
  - EXPOSE: Expose=1 for exactly E*CLK_PER_MS cycles, then go to READ1.
  - READ1: NRE_1=0 for 2*CLK_PER_MS cycles. ADC=1 for one cycle, on the last cycle of READ1. Then go to GAP.
  - GAP: all outputs idle except Busy=1, for CLK_PER_MS cycles. Then go to READ2.
  - READ2: same as READ1, using NRE_2. Then go to DONE.
  - DONE: Done=1 and Busy=1 for exactly one cycle, then go to IDLE.
- Duration counting:
  - A single phase counter is reloaded on every state entry.
  - Maximum count is 30*65535 cycles, so the counter is at least 21 bits wide.
  - The counter never wraps; its terminal count triggers the state change.
- Ignored inputs:
  - Init is ignored while Busy=1 (no queueing).
  - Changes on Exp_Time after latching do not affect the running capture.
- Abort:
  - Abort=1 in any non-IDLE state except DONE returns to IDLE on the next edge, with no Done pulse.
  - In DONE, the Done pulse completes normally.
  - In IDLE, Abort=1 is ignored.
  - If Init and Abort are both high in IDLE, Init wins.
- Back-to-back captures: Init high in the cycle after DONE (state IDLE) starts a new capture. The minimum IDLE dwell is 1 cycle.
- Total capture latency, from the Init edge to the Done cycle: (ERASE_MS + E + 5)*CLK_PER_MS + 1 cycles.

Test Plan:
- Reset, then Init pulse with Exp_Time=15 and defaults -> ERASE 2 cycles, EXPOSE 15 cycles. READ1 2 cycles with NRE_1=0 and ADC on the 2nd, GAP 1, READ2 2 cycles. Done at cycle 23 after the Init edge; Busy high for 23 cycles.
- Exp_Time=0, then Exp_Time=31 (two separate captures) -> Expose width 2 cycles, then 30 cycles. Exp_Time changed to 9 during EXPOSE -> width unchanged.
- CLK_PER_MS=4, Exp_Time=3 -> Erase 8 cycles, Expose 12, NRE_1 low 8, GAP 4, NRE_2 low 8. ADC pulses are exactly 1 cycle wide.
- Abort asserted in the 5th EXPOSE cycle -> IDLE next edge, all outputs at idle values, no Done. A following Init starts a clean capture.
- Reset driven low mid-READ1, asynchronously between edges -> outputs reach idle values before the next Clk edge. Init held high during Reset is ignored until Reset returns high.
- Init held high continuously -> captures repeat with exactly one IDLE cycle between Done and the next Erase. Init pulses during Busy are ignored.
